// File: rtl/sdfa_neuron_core_if.sv
// Bus between the array controller and one neuron lane: spike/weight
// stream and window controls in, membrane sum and window-done flag out.
interface sdfa_neuron_core_if #(
    parameter int unsigned W_WIDTH   = 9,
    parameter int unsigned SUM_WIDTH = 10
);
    logic                 cal_en;
    logic                 new_block;
    logic                 read_done;
    logic                 input_spike;
    logic [W_WIDTH-1:0]   weight;
    logic [SUM_WIDTH-1:0] sum;
    logic                 cal_done;

    // Controller side
    modport master (
        output cal_en, new_block, read_done, input_spike, weight,
        input  sum, cal_done
    );

    // Neuron side
    modport slave (
        input  cal_en, new_block, read_done, input_spike, weight,
        output sum, cal_done
    );
endinterface

// File: rtl/sdfa_neuron_core.sv
// Single integrate neuron: saturating signed accumulation of spike-gated
// weights over a calculation window, with a done flag on window close.
module sdfa_neuron_core #(
    parameter int unsigned W_WIDTH   = 9,
    parameter int unsigned SUM_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    sdfa_neuron_core_if.slave     bus
);
    // One guard bit so the add can never wrap before clamping
    localparam int unsigned EXT_WIDTH = SUM_WIDTH + 1;

    localparam logic signed [EXT_WIDTH-1:0] SUM_MAX =
        {2'b00, {(SUM_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_WIDTH-1:0] SUM_MIN =
        {2'b11, {(SUM_WIDTH-1){1'b0}}};

    logic [SUM_WIDTH-1:0]        sum_q, sum_d;
    logic                        cal_done_q, cal_done_d;
    logic                        cal_en_d;
    logic                        accept;
    logic signed [EXT_WIDTH-1:0] weight_ext;
    logic signed [EXT_WIDTH-1:0] sum_ext;
    logic signed [EXT_WIDTH-1:0] sum_add;
    logic [SUM_WIDTH-1:0]        sum_sat;
    logic [SUM_WIDTH-1:0]        weight_sum;

    assign accept     = bus.cal_en & bus.input_spike;
    assign weight_ext = {{(EXT_WIDTH-W_WIDTH){bus.weight[W_WIDTH-1]}}, bus.weight};
    assign weight_sum = weight_ext[SUM_WIDTH-1:0];
    assign sum_ext    = {sum_q[SUM_WIDTH-1], sum_q};
    assign sum_add    = sum_ext + weight_ext;

    // Clamp the widened sum into the representable signed range
    always_comb begin
        sum_sat = sum_add[SUM_WIDTH-1:0];
        if (sum_add > SUM_MAX) begin
            sum_sat = SUM_MAX[SUM_WIDTH-1:0];
        end else if (sum_add < SUM_MIN) begin
            sum_sat = SUM_MIN[SUM_WIDTH-1:0];
        end
    end

    // Next-state: new_block > read_done > accumulate for sum; clears beat window-close set for done
    always_comb begin
        sum_d      = sum_q;
        cal_done_d = cal_done_q;
        if (bus.new_block) begin
            sum_d = accept ? weight_sum : '0;
        end else if (bus.read_done) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_sat;
        end
        if (bus.new_block || bus.read_done) begin
            cal_done_d = 1'b0;
        end else if (cal_en_d && !bus.cal_en) begin
            cal_done_d = 1'b1;
        end
    end

    // State registers; rstn is an active-high synchronous clear
    always_ff @(posedge clk) begin
        if (rstn) begin
            sum_q      <= '0;
            cal_done_q <= 1'b0;
            cal_en_d   <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            cal_done_q <= cal_done_d;
            cal_en_d   <= bus.cal_en;
        end
    end

    assign bus.sum      = sum_q;
    assign bus.cal_done = cal_done_q;
endmodule

// File: tb/tb_sdfa_neuron_core.sv
// Directed and randomized bench for sdfa_neuron_core against an
// integer-arithmetic model of the neuron.
module tb_sdfa_neuron_core;
    localparam int unsigned W_WIDTH   = 9;
    localparam int unsigned SUM_WIDTH = 10;
    localparam int          SAT_MAX   = 511;
    localparam int          SAT_MIN   = -512;

    logic clk;
    logic rstn;

    sdfa_neuron_core_if #(.W_WIDTH(W_WIDTH), .SUM_WIDTH(SUM_WIDTH)) bus ();

    sdfa_neuron_core #(.W_WIDTH(W_WIDTH), .SUM_WIDTH(SUM_WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    int m_sum    = 0;
    bit m_done   = 1'b0;
    bit m_en_prv = 1'b0;

    function automatic int clamp(input int v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    // Apply the neuron rules for one clock edge
    task automatic model_edge(input bit rst, input bit ce, input bit nb, input bit rd,
                              input bit sp, input logic [W_WIDTH-1:0] w);
        int  wv;
        bit  take;
        wv   = int'($signed(w));
        take = ce && sp;
        if (rst) begin
            m_sum    = 0;
            m_done   = 1'b0;
            m_en_prv = 1'b0;
        end else begin
            if (nb)        m_sum = take ? wv : 0;
            else if (rd)   m_sum = 0;
            else if (take) m_sum = clamp(m_sum + wv);
            if (nb || rd)                m_done = 1'b0;
            else if (m_en_prv && !ce)    m_done = 1'b1;
            m_en_prv = ce;
        end
    endtask

    task automatic check_model(input string tag);
        logic signed [SUM_WIDTH-1:0] obs;
        obs = $signed(bus.sum);
        n_assert++;
        assert (bus.sum === SUM_WIDTH'(m_sum))
        else begin
            n_fail++;
            $error("FAIL %s sum: observed=%0d expected=%0d", tag, obs, m_sum);
        end
        n_assert++;
        assert (bus.cal_done === m_done)
        else begin
            n_fail++;
            $error("FAIL %s cal_done: observed=%0b expected=%0b", tag, bus.cal_done, m_done);
        end
    endtask

    task automatic check_const(input string tag, input int exp_sum, input bit exp_done);
        logic signed [SUM_WIDTH-1:0] obs;
        obs = $signed(bus.sum);
        n_assert++;
        assert (bus.sum === SUM_WIDTH'(exp_sum))
        else begin
            n_fail++;
            $error("FAIL %s sum: observed=%0d expected=%0d", tag, obs, exp_sum);
        end
        n_assert++;
        assert (bus.cal_done === exp_done)
        else begin
            n_fail++;
            $error("FAIL %s cal_done: observed=%0b expected=%0b", tag, bus.cal_done, exp_done);
        end
    endtask

    // Drive one cycle away from the edge, clock it, then compare with the model
    task automatic step(input string tag, input bit rst, input bit ce, input bit nb,
                        input bit rd, input bit sp, input logic [W_WIDTH-1:0] w);
        @(negedge clk);
        rstn            = rst;
        bus.cal_en      = ce;
        bus.new_block   = nb;
        bus.read_done   = rd;
        bus.input_spike = sp;
        bus.weight      = w;
        @(posedge clk);
        model_edge(rst, ce, nb, rd, sp, w);
        #1;
        check_model(tag);
    endtask

    // Directed step with an additional hand-computed expectation
    task automatic dstep(input string tag, input bit ce, input bit nb, input bit rd,
                         input bit sp, input logic [W_WIDTH-1:0] w,
                         input int exp_sum, input bit exp_done);
        step(tag, 1'b0, ce, nb, rd, sp, w);
        check_const(tag, exp_sum, exp_done);
    endtask

    initial begin
        rstn            = 1'b1;
        bus.cal_en      = 1'b0;
        bus.new_block   = 1'b0;
        bus.read_done   = 1'b0;
        bus.input_spike = 1'b0;
        bus.weight      = '0;

        step("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        step("reset1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h005);
        check_const("reset_state", 0, 1'b0);

        // Basic accumulate and window close
        dstep("acc_w1",     1'b1, 1'b0, 1'b0, 1'b1, 9'd1, 1, 1'b0);
        dstep("acc_w2",     1'b1, 1'b0, 1'b0, 1'b1, 9'd2, 3, 1'b0);
        dstep("gate_off_3", 1'b0, 1'b0, 1'b0, 1'b1, 9'd3, 3, 1'b1);
        dstep("gate_off_4", 1'b0, 1'b0, 1'b0, 1'b1, 9'd4, 3, 1'b1);

        // Spike gating, negatives, done stays set on re-enable
        dstep("reenable_5", 1'b1, 1'b0, 1'b0, 1'b1, 9'd5, 8, 1'b1);
        dstep("nospike_6",  1'b1, 1'b0, 1'b0, 1'b0, 9'd6, 8, 1'b1);
        dstep("nospike_7",  1'b1, 1'b0, 1'b0, 1'b0, 9'd7, 8, 1'b1);
        dstep("nospike_8",  1'b1, 1'b0, 1'b0, 1'b0, 9'd8, 8, 1'b1);
        dstep("neg_one",    1'b1, 1'b0, 1'b0, 1'b1, 9'h1FF, 7, 1'b1);

        // Negative saturation
        dstep("neg_256a",   1'b1, 1'b0, 1'b0, 1'b1, 9'h100, -249, 1'b1);
        dstep("neg_256b",   1'b1, 1'b0, 1'b0, 1'b1, 9'h100, -505, 1'b1);
        dstep("neg_clamp",  1'b1, 1'b0, 1'b0, 1'b1, 9'h180, -512, 1'b1);
        dstep("neg_recover",1'b1, 1'b0, 1'b0, 1'b1, 9'd12, -500, 1'b1);

        // New block without a spike clears to zero; then positive saturation
        dstep("nb_zero",    1'b1, 1'b1, 1'b0, 1'b0, 9'd77, 0, 1'b0);
        dstep("pos_255a",   1'b1, 1'b0, 1'b0, 1'b1, 9'd255, 255, 1'b0);
        dstep("pos_255b",   1'b1, 1'b0, 1'b0, 1'b1, 9'd255, 510, 1'b0);
        dstep("pos_clamp",  1'b1, 1'b0, 1'b0, 1'b1, 9'd255, 511, 1'b0);
        dstep("pos_hold",   1'b1, 1'b0, 1'b0, 1'b1, 9'd255, 511, 1'b0);
        dstep("pos_recover",1'b1, 1'b0, 1'b0, 1'b1, 9'h1FF, 510, 1'b0);

        // Close window, then read_done discards the concurrent weight
        dstep("close_win",  1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 510, 1'b1);
        dstep("read_done",  1'b1, 1'b0, 1'b1, 1'b1, 9'd5, 0, 1'b0);
        dstep("rd_acc1",    1'b1, 1'b0, 1'b0, 1'b1, 9'd1, 1, 1'b0);
        dstep("rd_acc2",    1'b1, 1'b0, 1'b0, 1'b1, 9'd2, 3, 1'b0);
        dstep("rd_acc3",    1'b1, 1'b0, 1'b0, 1'b1, 9'd3, 6, 1'b0);
        dstep("close_win2", 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6, 1'b1);

        // New block with spike loads the weight and clears done
        dstep("nb_load",    1'b1, 1'b1, 1'b0, 1'b1, 9'd4, 4, 1'b0);

        // Clear wins over a window-close set in the same cycle
        dstep("rd_vs_set",  1'b0, 1'b0, 1'b1, 1'b1, 9'd9, 0, 1'b0);
        dstep("acc_again",  1'b1, 1'b0, 1'b0, 1'b1, 9'd20, 20, 1'b0);
        dstep("nb_vs_set",  1'b0, 1'b1, 1'b0, 1'b1, 9'd9, 0, 1'b0);

        // Reset mid-window
        dstep("pre_rst",    1'b1, 1'b0, 1'b0, 1'b1, 9'd33, 33, 1'b0);
        step("mid_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'd44);
        check_const("mid_rst_const", 0, 1'b0);
        dstep("post_rst",   1'b0, 1'b0, 1'b0, 1'b1, 9'd44, 0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit                 r_rst, r_ce, r_nb, r_rd, r_sp;
            logic [W_WIDTH-1:0] r_w;
            r_rst = ($urandom_range(0, 79) == 0);
            r_nb  = ($urandom_range(0, 19) == 0);
            r_rd  = ($urandom_range(0, 14) == 0);
            r_ce  = ($urandom_range(0, 4) != 0);
            r_sp  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0)
                r_w = $urandom_range(0, 1) ? 9'h0FF : 9'h100;
            else
                r_w = W_WIDTH'($urandom_range(0, 511));
            step("random", r_rst, r_ce, r_nb, r_rd, r_sp, r_w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sdfa_neuron_core.md
Name: sdfa_neuron_core

Overview:
- Single integrate neuron for the SDFA spiking datapath.
- Accumulates signed synaptic weights into a saturating signed membrane sum whenever an input spike arrives during a calculation window.
- Flags the end of a window with cal_done, and the sum is cleared by a read handshake or a new block.
- Instantiated once per neuron lane under the array controller, which drives weight and spike streams.

Parameters:
- W_WIDTH, 9: weight width, two's complement.
- SUM_WIDTH, 10: accumulator and output width, two's complement; must be > W_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  reset; synchronous, active-high: asserted (1) clears state at the next clk edge. The port name is kept from the codebase despite the active-high polarity.
- cal_en  input  1  calculation window enable; accumulation is allowed only while 1.
- new_block  input  1  start of a new input block; restarts the accumulation.
- read_done  input  1  consumer has read sum; clears sum and cal_done.
- input_spike  input  1  presynaptic spike for the current cycle.
- weight  input  W_WIDTH  signed weight paired with input_spike this cycle.
- sum  output  SUM_WIDTH  registered signed membrane sum.
- cal_done  output  1  registered; window finished, sum is valid.

Behaviour:
- All state updates on the rising edge of clk. sum and cal_done are direct register outputs with no combinational path from the inputs.
- An internal register cal_en_d holds cal_en from the previous cycle.
- Reset (rstn=1): sum=0, cal_done=0, cal_en_d=0. Reset overrides every other input, including in the middle of a window.
- Per-edge priority for sum, highest first:
  - new_block=1: sum <= (cal_en & input_spike) ? sext(weight) : 0. This starts a fresh accumulation in the same cycle.
  - read_done=1: sum <= 0. The current weight is discarded even if cal_en & input_spike.
  - cal_en=1 and input_spike=1: sum <= sat(sum + sext(weight)).
  - otherwise: sum holds.
- sat(): compute at SUM_WIDTH+1 bits, then clamp to [-(2^(SUM_WIDTH-1)), 2^(SUM_WIDTH-1)-1], i.e. [-512, +511] by default. The result never wraps.
- cal_done:
  - Cleared by new_block or read_done; these win over a set in the same cycle.
  - Set when cal_en_d=1 and cal_en=0 (falling edge of the window).
  - Otherwise holds.
  - Re-asserting cal_en does not clear it.
- Latency: a weight presented in cycle N is reflected on sum after edge N, i.e. visible in cycle N+1.
- A 0 spike, or cal_en=0, means weight is ignored.
- Weight is sign-extended: 9'h1FF means -1, 9'h100 means -256.
- Once saturated, sum may move back toward zero with opposite-sign weights.

Test Plan:
- Basic accumulate:
  - After reset, cal_en=1, spike=1, weights 1,2 on consecutive cycles -> sum 1 then 3.
  - Drop cal_en for 2 cycles with weights 3,4 -> sum holds 3, and cal_done=1 after the cycle cal_en fell.
- Spike gating and negatives:
  - cal_en=1, weight 5 -> sum 8.
  - spike=0 with weights 6,7,8 -> sum stays 8.
  - spike=1, weight 9'h1FF -> sum 7.
- Negative saturation: from sum 7, weights 9'h100, 9'h100, 9'h180 -> sum -249, -505, then -512 (clamped, not -633).
- Positive saturation: repeated weight 255 from 0 -> sum 255, 510, then 511 and held at 511.
- read_done:
  - One-cycle read_done -> sum=0 and cal_done=0 next cycle.
  - Then weights 1,2,3 with spike -> sum 1, 3, 6.
- new_block:
  - With sum=6 and cal_done=1, new_block=1, cal_en=1, spike=1, weight 4 -> sum=4, cal_done=0.
  - Assert rstn for one cycle mid-window -> sum=0, cal_done=0.
